// File: rtl/ct_spsram_acc_ctrl.sv
// Access controller for a single-port SRAM macro: zero-fills the array after
// reset, then turns a valid/ready request stream into SRAM pin activity and
// returns read data in order through a credit-limited response FIFO.
module ct_spsram_acc_ctrl #(
   parameter int unsigned ADDR_WIDTH = 9,
   parameter int unsigned DATA_WIDTH = 144,
   parameter int unsigned RD_LAT     = 1
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   output logic                  init_done,
   input  logic                  req_vld,
   output logic                  req_rdy,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [DATA_WIDTH-1:0] req_wmask,
   output logic                  rsp_vld,
   input  logic                  rsp_rdy,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic                  sram_cen,
   output logic                  sram_gwen,
   output logic [DATA_WIDTH-1:0] sram_wen,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q
);

   // One FIFO slot per cycle of read latency plus one, so a stalled consumer
   // never loses data that is already in flight.
   localparam int unsigned DEPTH = RD_LAT + 1;
   localparam int unsigned CW    = $clog2(DEPTH + 1);
   localparam int unsigned PW    = $clog2(DEPTH);

   typedef enum logic [0:0] {StInit, StRun} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [CW-1:0]         ocnt_q, ocnt_d;
   logic [CW-1:0]         fcnt_q, fcnt_d;
   logic [RD_LAT-1:0]     rvld_q, rvld_d;
   logic [PW-1:0]         wptr_q, wptr_d;
   logic [PW-1:0]         rptr_q, rptr_d;
   logic [DATA_WIDTH-1:0] fifo_mem [DEPTH];
   logic                  access;
   logic                  rd_acc;
   logic                  push;
   logic                  pop;
   logic                  full;

   // State register and sweep address counter
   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) begin
         state_q <= StInit;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: sweep every address once, then run
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == StInit) begin
         cnt_d = cnt_q + ADDR_WIDTH'(1);
         if (&cnt_q) begin
            state_d = StRun;
         end
      end
   end

   // Response side: FIFO head, pop handshake and push from the latency pipe
   always_comb begin
      rsp_vld   = (fcnt_q != '0);
      pop       = rsp_vld & rsp_rdy;
      rsp_rdata = rsp_vld ? fifo_mem[rptr_q] : '0;
      push      = rvld_q[RD_LAT-1];
      full      = (fcnt_q == CW'(DEPTH));
   end

   // Outputs: request handshake and SRAM pins; sweep writes are gated by reset
   always_comb begin
      init_done = (state_q == StRun);
      // A pop frees a credit in the same cycle, so ready may rise combinationally.
      req_rdy   = cpurst_b & init_done & ((ocnt_q < CW'(DEPTH)) | pop);
      access    = req_vld & req_rdy;
      rd_acc    = access & ~req_wr;
      if (state_q == StInit) begin
         sram_a    = cnt_q;
         sram_d    = '0;
         sram_cen  = ~cpurst_b;
         sram_gwen = ~cpurst_b;
         sram_wen  = {DATA_WIDTH{~cpurst_b}};
      end else begin
         sram_a    = req_addr;
         sram_d    = req_wdata;
         sram_cen  = ~access;
         sram_gwen = ~(access & req_wr);
         sram_wen  = (access & req_wr) ? ~req_wmask : '1;
      end
   end

   // Next values for the read tag pipe, credit counter and FIFO pointers
   always_comb begin
      rvld_d[0] = rd_acc;
      for (int i = 1; i < RD_LAT; i++) begin
         rvld_d[i] = rvld_q[i-1];
      end
      ocnt_d = ocnt_q + CW'(rd_acc) - CW'(pop);
      fcnt_d = fcnt_q + CW'(push) - CW'(pop);
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push) begin
         wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
      end
      if (pop) begin
         rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
      end
   end

   // Read pipeline control state; reset drops everything in flight
   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) begin
         rvld_q <= '0;
         ocnt_q <= '0;
         fcnt_q <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         rvld_q <= rvld_d;
         ocnt_q <= ocnt_d;
         fcnt_q <= fcnt_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // FIFO storage captures sram_q only in the cycle the read tag exits
   always_ff @(posedge forever_cpuclk) begin
      if (push) begin
         fifo_mem[wptr_q] <= sram_q;
      end
   end

   // Credits must make overflow impossible
   assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b) !(push && full && !pop));

endmodule

// File: tb/tb_ct_spsram_acc_ctrl.sv
// Bench for ct_spsram_acc_ctrl: two instances (read latency 1 and 2), each with
// a behavioural SRAM macro, checked against a memory-array + response-queue model.
module tb_ct_spsram_acc_ctrl;

   localparam int unsigned AW = 9;
   localparam int unsigned DW = 144;
   localparam int unsigned NW = 1 << AW;
   localparam logic [DW-1:0] POISON = {9{16'hDEAD}};

   logic clk = 1'b0;
   logic cpurst_b = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]         init_done, req_vld, req_rdy, req_wr, rsp_vld, rsp_rdy;
   logic [1:0]         sram_cen, sram_gwen;
   logic [1:0][AW-1:0] req_addr, sram_a;
   logic [1:0][DW-1:0] req_wdata, req_wmask, rsp_rdata, sram_wen, sram_d, sram_q;

   ct_spsram_acc_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(1)) u_dut0 (
      .forever_cpuclk(clk), .cpurst_b(cpurst_b), .init_done(init_done[0]),
      .req_vld(req_vld[0]), .req_rdy(req_rdy[0]), .req_wr(req_wr[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
      .rsp_vld(rsp_vld[0]), .rsp_rdy(rsp_rdy[0]), .rsp_rdata(rsp_rdata[0]),
      .sram_a(sram_a[0]), .sram_cen(sram_cen[0]), .sram_gwen(sram_gwen[0]),
      .sram_wen(sram_wen[0]), .sram_d(sram_d[0]), .sram_q(sram_q[0])
   );

   ct_spsram_acc_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(2)) u_dut1 (
      .forever_cpuclk(clk), .cpurst_b(cpurst_b), .init_done(init_done[1]),
      .req_vld(req_vld[1]), .req_rdy(req_rdy[1]), .req_wr(req_wr[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
      .rsp_vld(rsp_vld[1]), .rsp_rdy(rsp_rdy[1]), .rsp_rdata(rsp_rdata[1]),
      .sram_a(sram_a[1]), .sram_cen(sram_cen[1]), .sram_gwen(sram_gwen[1]),
      .sram_wen(sram_wen[1]), .sram_d(sram_d[1]), .sram_q(sram_q[1])
   );

   // Behavioural macros; read data is poisoned outside its valid cycle
   logic [DW-1:0] mem0 [NW];
   logic [DW-1:0] mem1 [NW];
   logic [DW-1:0] s1_q;

   always @(posedge clk) begin
      if (!sram_cen[0] && !sram_gwen[0])
         mem0[sram_a[0]] <= (mem0[sram_a[0]] & sram_wen[0]) | (sram_d[0] & ~sram_wen[0]);
      sram_q[0] <= (!sram_cen[0] && sram_gwen[0]) ? mem0[sram_a[0]] : POISON;
   end

   always @(posedge clk) begin
      if (!sram_cen[1] && !sram_gwen[1])
         mem1[sram_a[1]] <= (mem1[sram_a[1]] & sram_wen[1]) | (sram_d[1] & ~sram_wen[1]);
      s1_q      <= (!sram_cen[1] && sram_gwen[1]) ? mem1[sram_a[1]] : POISON;
      sram_q[1] <= s1_q;
   end

   // Reference model: array contents plus in-order expected read responses
   logic [DW-1:0] ref_mem [2][NW];
   logic [DW-1:0] exp_q0 [$];
   logic [DW-1:0] exp_q1 [$];

   int checks = 0;
   int errors = 0;

   logic          o_acc, o_pop, o_ok;
   logic [DW-1:0] o_exp, o_got;

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] r;
      for (int i = 0; i < DW / 16; i++) r[i*16 +: 16] = 16'($urandom());
      return r;
   endfunction

   task automatic reset_model();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < NW; i++) ref_mem[d][i] = '0;
      exp_q0.delete();
      exp_q1.delete();
   endtask

   // One cycle on instance d: drive at negedge, observe 1 time unit later
   task automatic cyc(input int d, input logic vld, input logic wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic [DW-1:0] wmask, input logic rrdy);
      @(negedge clk);
      req_vld[d] = vld; req_wr[d] = wr; req_addr[d] = addr;
      req_wdata[d] = wdata; req_wmask[d] = wmask; rsp_rdy[d] = rrdy;
      #1;
      o_acc = vld & req_rdy[d];
      o_pop = rsp_vld[d] & rrdy;
      o_got = rsp_rdata[d];
      o_ok  = 1'b0;
      o_exp = '0;
      if (o_pop) begin
         if (d == 0 && exp_q0.size() > 0) begin o_exp = exp_q0.pop_front(); o_ok = 1'b1; end
         if (d == 1 && exp_q1.size() > 0) begin o_exp = exp_q1.pop_front(); o_ok = 1'b1; end
      end
      if (o_acc) begin
         if (wr) ref_mem[d][addr] = (ref_mem[d][addr] & ~wmask) | (wdata & wmask);
         else if (d == 0) exp_q0.push_back(ref_mem[d][addr]);
         else exp_q1.push_back(ref_mem[d][addr]);
      end
   endtask

   // Releases reset and observes the zero-fill sweep on both instances
   task automatic sweep_obs(output int bad, output int first_bad);
      bad = 0;
      first_bad = -1;
      @(negedge clk);
      cpurst_b = 1'b1;
      #1;
      for (int k = 0; k < NW; k++) begin
         if (k > 0) begin @(negedge clk); #1; end
         for (int d = 0; d < 2; d++) begin
            if (sram_cen[d] !== 1'b0 || sram_gwen[d] !== 1'b0 || sram_wen[d] !== '0 ||
                sram_d[d] !== '0 || sram_a[d] !== AW'(k) || init_done[d] !== 1'b0 ||
                req_rdy[d] !== 1'b0 || rsp_vld[d] !== 1'b0) begin
               bad++;
               if (first_bad < 0) first_bad = k;
            end
         end
      end
      @(negedge clk);
      req_vld = '0;
      #1;
   endtask

   task automatic test_reset();
      req_vld = '1; req_wr = '0; rsp_rdy = '1;
      cpurst_b = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({init_done[d], req_rdy[d], rsp_vld[d], sram_cen[d], sram_gwen[d]} !== 5'b00011 ||
             rsp_rdata[d] !== '0 || sram_wen[d] !== '1) begin
            errors++;
            $display("FAIL reset_vals dut%0d got done/rdy/vld/cen/gwen=%b%b%b%b%b exp=00011",
                     d, init_done[d], req_rdy[d], rsp_vld[d], sram_cen[d], sram_gwen[d]);
         end
      end
   endtask

   task automatic test_init_sweep();
      int bad, fb;
      sweep_obs(bad, fb);
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL init_sweep got %0d bad cycles (first %0d) exp 0", bad, fb);
      end
      checks++;
      if (init_done !== 2'b11 || req_rdy !== 2'b11) begin
         errors++;
         $display("FAIL init_done got done=%b rdy=%b exp 11/11", init_done, req_rdy);
      end
      reset_model();
      cyc(0, 1'b1, 1'b0, 9'h1FF, '0, '0, 1'b1);
      cyc(0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
      cyc(0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
      checks++;
      if (!o_pop || !o_ok || o_got !== '0) begin
         errors++;
         $display("FAIL sweep_read pop=%b got=%h exp=0", o_pop, o_got);
      end
   endtask

   task automatic test_write_read();
      logic [DW-1:0] data;
      data = 144'h123456789ABCDEF0123456789ABCDEF01ABC;
      cyc(0, 1'b1, 1'b1, 9'h005, data, '1, 1'b1);
      checks++;
      if (!o_acc || sram_cen[0] !== 1'b0 || sram_gwen[0] !== 1'b0 || sram_wen[0] !== '0 ||
          sram_a[0] !== 9'h005 || sram_d[0] !== data) begin
         errors++;
         $display("FAIL wr_pins got acc=%b cen=%b gwen=%b a=%h exp 1/0/0/005",
                  o_acc, sram_cen[0], sram_gwen[0], sram_a[0]);
      end
      cyc(0, 1'b1, 1'b0, 9'h005, '0, '0, 1'b1);
      checks++;
      if (!o_acc || sram_cen[0] !== 1'b0 || sram_gwen[0] !== 1'b1 || sram_wen[0] !== '1 ||
          sram_a[0] !== 9'h005) begin
         errors++;
         $display("FAIL rd_pins got acc=%b cen=%b gwen=%b a=%h exp 1/0/1/005",
                  o_acc, sram_cen[0], sram_gwen[0], sram_a[0]);
      end
      cyc(0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
      checks++;
      if (rsp_vld[0] !== 1'b0) begin
         errors++;
         $display("FAIL rd_early got rsp_vld=%b exp 0 at T+1", rsp_vld[0]);
      end
      cyc(0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
      checks++;
      if (!o_pop || !o_ok || o_got !== data || o_exp !== data) begin
         errors++;
         $display("FAIL rd_data pop=%b got=%h exp=%h", o_pop, o_got, data);
      end
   endtask

   task automatic test_masked_write();
      logic [AW-1:0] a;
      logic [DW-1:0] exp_m;
      a = AW'($urandom_range(16, NW - 1));
      exp_m = '1;
      exp_m[7:0] = 8'h00;
      cyc(0, 1'b1, 1'b1, a, '1, '1, 1'b1);
      cyc(0, 1'b1, 1'b1, a, '0, 144'hFF, 1'b1);
      cyc(0, 1'b1, 1'b1, a, rand_data(), '0, 1'b1);
      checks++;
      if (!o_acc || sram_cen[0] !== 1'b0 || sram_gwen[0] !== 1'b0 || sram_wen[0] !== '1) begin
         errors++;
         $display("FAIL zero_mask_pins got acc=%b cen=%b gwen=%b wen=%h exp 1/0/0/all-ones",
                  o_acc, sram_cen[0], sram_gwen[0], sram_wen[0]);
      end
      cyc(0, 1'b1, 1'b0, a, '0, '0, 1'b1);
      cyc(0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
      cyc(0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
      checks++;
      if (!o_pop || !o_ok || o_got !== exp_m || o_got !== o_exp) begin
         errors++;
         $display("FAIL masked_data pop=%b got=%h exp=%h", o_pop, o_got, exp_m);
      end
   endtask

   task automatic test_backpressure();
      logic [AW-1:0] addrs [4];
      int base, idx, acc_n, pops, first_pop, last_pop;
      base = $urandom_range(0, 400);
      for (int i = 0; i < 4; i++) begin
         addrs[i] = AW'(base + i * 3);
         cyc(0, 1'b1, 1'b1, addrs[i], rand_data(), '1, 1'b1);
      end
      idx = 0;
      acc_n = 0;
      for (int c = 0; c < 6; c++) begin
         cyc(0, 1'b1, 1'b0, addrs[idx], '0, '0, 1'b0);
         if (o_acc) begin idx++; acc_n++; end
      end
      checks++;
      if (acc_n != 2 || req_rdy[0] !== 1'b0 || rsp_vld[0] !== 1'b1) begin
         errors++;
         $display("FAIL bp_accept got accepted=%0d rdy=%b vld=%b exp 2/0/1",
                  acc_n, req_rdy[0], rsp_vld[0]);
      end
      pops = 0;
      first_pop = -1;
      last_pop = -1;
      for (int c = 0; c < 10; c++) begin
         cyc(0, idx < 4, 1'b0, addrs[idx < 4 ? idx : 0], '0, '0, 1'b1);
         if (c == 0) begin
            checks++;
            if (req_rdy[0] !== 1'b1) begin
               errors++;
               $display("FAIL bp_rdy_pop got req_rdy=%b exp 1", req_rdy[0]);
            end
         end
         if (o_acc) idx++;
         if (o_pop) begin
            pops++;
            if (first_pop < 0) first_pop = c;
            last_pop = c;
            checks++;
            if (!o_ok || o_got !== o_exp) begin
               errors++;
               $display("FAIL bp_data got=%h exp=%h", o_got, o_exp);
            end
         end
      end
      checks++;
      if (pops != 4 || last_pop - first_pop != 3 || idx != 4) begin
         errors++;
         $display("FAIL bp_stream got pops=%0d span=%0d issued=%0d exp 4/3/4",
                  pops, last_pop - first_pop, idx);
      end
   endtask

   task automatic test_random();
      logic vld, wr, rr;
      for (int c = 0; c < 408; c++) begin
         vld = (c < 400) && ($urandom_range(0, 3) != 0);
         wr  = 1'($urandom_range(0, 1));
         rr  = (c >= 400) || ($urandom_range(0, 3) != 0);
         cyc(0, vld, wr, AW'($urandom_range(0, 15)), rand_data(), rand_data(), rr);
         if (o_pop) begin
            checks++;
            if (!o_ok || o_got !== o_exp) begin
               errors++;
               $display("FAIL rand_data cycle %0d got=%h exp=%h", c, o_got, o_exp);
            end
         end
      end
      checks++;
      if (exp_q0.size() != 0 || rsp_vld[0] !== 1'b0) begin
         errors++;
         $display("FAIL rand_drain got pending=%0d vld=%b exp 0/0", exp_q0.size(), rsp_vld[0]);
      end
   endtask

   task automatic test_rdlat2_stream();
      logic [AW-1:0] tbl [16];
      int n_iss, stalls, first_acc, first_pop, last_pop, pops;
      for (int i = 0; i < 16; i++) begin
         tbl[i] = AW'($urandom_range(0, NW - 1));
         cyc(1, 1'b1, 1'b1, tbl[i], rand_data(), rand_data(), 1'b1);
      end
      repeat (3) cyc(1, 1'b0, 1'b0, '0, '0, '0, 1'b1);
      n_iss = 0; stalls = 0; first_acc = -1; first_pop = -1; last_pop = -1; pops = 0;
      for (int c = 0; c < 110; c++) begin
         cyc(1, n_iss < 100, 1'b0, tbl[$urandom_range(0, 15)], '0, '0, 1'b1);
         if (n_iss < 100 && !o_acc) stalls++;
         if (o_acc) begin
            if (first_acc < 0) first_acc = c;
            n_iss++;
         end
         if (o_pop) begin
            pops++;
            if (first_pop < 0) first_pop = c;
            last_pop = c;
            checks++;
            if (!o_ok || o_got !== o_exp) begin
               errors++;
               $display("FAIL s2_data cycle %0d got=%h exp=%h", c, o_got, o_exp);
            end
         end
      end
      checks++;
      if (stalls != 0 || n_iss != 100) begin
         errors++;
         $display("FAIL s2_issue got stalls=%0d issued=%0d exp 0/100", stalls, n_iss);
      end
      checks++;
      if (first_pop - first_acc != 3) begin
         errors++;
         $display("FAIL s2_first got latency=%0d exp 3", first_pop - first_acc);
      end
      checks++;
      if (pops != 100 || last_pop - first_pop != 99) begin
         errors++;
         $display("FAIL s2_stream got pops=%0d span=%0d exp 100/99", pops, last_pop - first_pop);
      end
   endtask

   task automatic test_reset_mid();
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      int acc_n, bad, fb;
      a = AW'($urandom_range(16, NW - 1));
      wd = rand_data();
      wd[0] = 1'b1;
      cyc(0, 1'b1, 1'b1, a, wd, '1, 1'b1);
      acc_n = 0;
      for (int c = 0; c < 4; c++) begin
         cyc(0, 1'b1, 1'b0, a, '0, '0, 1'b0);
         if (o_acc) acc_n++;
      end
      checks++;
      if (acc_n != 2 || rsp_vld[0] !== 1'b1 || rsp_rdata[0] !== wd) begin
         errors++;
         $display("FAIL rm_pre got accepted=%0d vld=%b data=%h exp 2/1/%h",
                  acc_n, rsp_vld[0], rsp_rdata[0], wd);
      end
      @(negedge clk);
      cpurst_b = 1'b0;
      req_vld = '0;
      rsp_rdy = '0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (rsp_vld !== 2'b00 || init_done !== 2'b00) begin
         errors++;
         $display("FAIL rm_rst_vld got vld=%b done=%b exp 00/00", rsp_vld, init_done);
      end
      rsp_rdy = '1;
      sweep_obs(bad, fb);
      checks++;
      if (bad != 0 || init_done !== 2'b11) begin
         errors++;
         $display("FAIL rm_sweep got %0d bad cycles (first %0d) done=%b exp 0/11",
                  bad, fb, init_done);
      end
      reset_model();
      cyc(0, 1'b1, 1'b0, a, '0, '0, 1'b1);
      cyc(0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
      cyc(0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
      checks++;
      if (!o_pop || !o_ok || o_got !== '0) begin
         errors++;
         $display("FAIL rm_read pop=%b got=%h exp=0", o_pop, o_got);
      end
   endtask

   initial begin
      for (int i = 0; i < NW; i++) begin
         mem0[i] <= POISON;
         mem1[i] <= POISON;
      end
      req_vld = '0; req_wr = '0; req_addr = '0;
      req_wdata = '0; req_wmask = '0; rsp_rdy = '1;
      reset_model();
      test_reset();
      test_init_sweep();
      test_write_read();
      test_masked_write();
      test_backpressure();
      test_random();
      test_rdlat2_stream();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
